// File: rtl/sram_port_arbiter_if.sv
// Requester-side bus of the SRAM port arbiter: flattened request fields,
// one-hot grant and the tagged read return.
interface sram_port_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32
);
    localparam int WM_W = DATA_W / 8;

    logic [NUM_REQ-1:0]        IN_valid;
    logic [NUM_REQ-1:0]        IN_we;
    logic                      IN_lock;
    logic [NUM_REQ*ADDR_W-1:0] IN_addr;
    logic [NUM_REQ*DATA_W-1:0] IN_data;
    logic [NUM_REQ*WM_W-1:0]   IN_wm;
    logic [NUM_REQ-1:0]        OUT_ready;
    logic [NUM_REQ-1:0]        OUT_rvalid;
    logic [DATA_W-1:0]         OUT_rdata;
    logic                      OUT_rerr;

    modport master (
        output IN_valid, IN_we, IN_lock, IN_addr, IN_data, IN_wm,
        input  OUT_ready, OUT_rvalid, OUT_rdata, OUT_rerr
    );

    modport slave (
        input  IN_valid, IN_we, IN_lock, IN_addr, IN_data, IN_wm,
        output OUT_ready, OUT_rvalid, OUT_rdata, OUT_rerr
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// N-requester arbiter for a single-port cache SRAM: fixed priority with burst
// lock for PRIO_REQ, round-robin for the rest, registered command, tagged return.
module sram_port_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int PRIO_REQ   = 0,
    parameter int ADDR_W     = 30,
    parameter int SRAM_AW    = 10,
    parameter int SRAM_WORDS = 1024,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_port_arbiter_if.slave    req,
    output logic                  OUT_SRAM_nce,
    output logic                  OUT_SRAM_nwe,
    output logic [SRAM_AW-1:0]    OUT_SRAM_addr,
    output logic [DATA_W-1:0]     OUT_SRAM_data,
    output logic [DATA_W/8-1:0]   OUT_SRAM_wm,
    input  logic [DATA_W-1:0]     IN_SRAM_data,
    output logic [CNT_W-1:0]      OUT_conflicts
);
    localparam int WM_W  = DATA_W / 8;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] PRIO_IDX = IDX_W'(PRIO_REQ);
    localparam logic [IDX_W-1:0] RR_RESET = (PRIO_REQ == 0) ? IDX_W'(1) : '0;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] k);
        return (int'(k) == NUM_REQ - 1) ? '0 : k + IDX_W'(1);
    endfunction

    // Next non-priority index after k; PRIO_REQ never holds the pointer.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] k);
        logic [IDX_W-1:0] j;
        j = wrap_inc(k);
        if (j == PRIO_IDX) j = wrap_inc(j);
        return j;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic                 lock_q;
    logic [IDX_W-1:0]     rr_q;
    logic [CNT_W-1:0]     conflicts_q;

    logic [NUM_REQ-1:0]   gnt_p0;
    logic                 acc_p0;
    logic [IDX_W-1:0]     acc_idx_p0;
    logic [IDX_W-1:0]     scan_idx;
    logic                 found;
    logic                 sel_we_p0;
    logic [ADDR_W-1:0]    sel_addr_p0;
    logic [DATA_W-1:0]    sel_data_p0;
    logic [WM_W-1:0]      sel_wm_p0;
    logic                 in_range_p0;

    logic                 nce_p1, nwe_p1;
    logic [SRAM_AW-1:0]   addr_p1;
    logic [DATA_W-1:0]    data_p1;
    logic [WM_W-1:0]      wm_p1;
    logic                 vld_p1, err_p1;
    logic [NUM_REQ-1:0]   tag_p1;
    logic                 vld_p2, err_p2;
    logic [NUM_REQ-1:0]   tag_p2;

    // Stage p0: grant and selection of the accepted request
    always_comb begin
        gnt_p0   = '0;
        found    = 1'b0;
        scan_idx = rr_q;
        if (!rst) begin
            gnt_p0 = '0;
        end else if (lock_q && req.IN_lock) begin
            gnt_p0[PRIO_REQ] = req.IN_valid[PRIO_REQ];
        end else if (req.IN_valid[PRIO_REQ]) begin
            gnt_p0[PRIO_REQ] = 1'b1;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && scan_idx != PRIO_IDX && req.IN_valid[scan_idx]) begin
                    gnt_p0[scan_idx] = 1'b1;
                    found            = 1'b1;
                end
                scan_idx = wrap_inc(scan_idx);
            end
        end
    end

    always_comb begin
        acc_p0      = |gnt_p0;
        acc_idx_p0  = '0;
        sel_we_p0   = 1'b0;
        sel_addr_p0 = '0;
        sel_data_p0 = '0;
        sel_wm_p0   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_p0[i]) begin
                acc_idx_p0  = IDX_W'(i);
                sel_we_p0   = req.IN_we[i];
                sel_addr_p0 = req.IN_addr[i*ADDR_W +: ADDR_W];
                sel_data_p0 = req.IN_data[i*DATA_W +: DATA_W];
                sel_wm_p0   = req.IN_wm[i*WM_W +: WM_W];
            end
        end
        in_range_p0 = sel_addr_p0 < ADDR_W'(SRAM_WORDS);
    end

    assign req.OUT_ready = gnt_p0;

    // Stage p1: registered SRAM command; stage p2: return tag aligned with SRAM data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q      <= 1'b0;
            rr_q        <= RR_RESET;
            conflicts_q <= '0;
            nce_p1      <= 1'b1;
            nwe_p1      <= 1'b1;
            addr_p1     <= '0;
            data_p1     <= '0;
            wm_p1       <= '0;
            vld_p1      <= 1'b0;
            err_p1      <= 1'b0;
            tag_p1      <= '0;
            vld_p2      <= 1'b0;
            err_p2      <= 1'b0;
            tag_p2      <= '0;
        end else begin
            lock_q <= req.IN_lock && (lock_q || gnt_p0[PRIO_REQ]);
            if (acc_p0 && acc_idx_p0 != PRIO_IDX) rr_q <= rr_next(acc_idx_p0);
            if ($countones(req.IN_valid) >= 2) conflicts_q <= sat_inc(conflicts_q);

            nce_p1 <= 1'b1;
            nwe_p1 <= 1'b1;
            if (acc_p0 && in_range_p0) begin
                nce_p1  <= 1'b0;
                nwe_p1  <= ~sel_we_p0;
                addr_p1 <= sel_addr_p0[SRAM_AW-1:0];
                data_p1 <= sel_data_p0;
                wm_p1   <= ~sel_wm_p0;
            end
            vld_p1 <= acc_p0 && !sel_we_p0;
            err_p1 <= !in_range_p0;
            tag_p1 <= gnt_p0;

            vld_p2 <= vld_p1;
            err_p2 <= err_p1;
            tag_p2 <= tag_p1;
        end
    end

    assign OUT_SRAM_nce  = nce_p1;
    assign OUT_SRAM_nwe  = nwe_p1;
    assign OUT_SRAM_addr = addr_p1;
    assign OUT_SRAM_data = data_p1;
    assign OUT_SRAM_wm   = wm_p1;
    assign OUT_conflicts = conflicts_q;

    assign req.OUT_rvalid = vld_p2 ? tag_p2 : '0;
    assign req.OUT_rerr   = vld_p2 && err_p2;
    assign req.OUT_rdata  = (vld_p2 && !err_p2) ? IN_SRAM_data : '0;
endmodule
